// File: rtl/spk_tone_scheduler.sv
// Round-robin arbiter that shares one tone generator. Grant takes one cycle and the tone starts on the next cycle.
// Requesters hold valid until they see their req_ready pulse. Requests are not accepted while a tone or gap is active.
module spk_tone_scheduler #(
   parameter int NUM_REQ  = 4,
   parameter int HP_W     = 16,
   parameter int DUR_W    = 12,
   parameter int TICK_CYC = 32000,
   parameter int GAP_MS   = 10,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*HP_W-1:0]  req_half_period,
   input  logic [NUM_REQ*DUR_W-1:0] req_dur_ms,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic                     abort,
   output logic                     tone_on,
   output logic [HP_W-1:0]          tone_half_period,
   output logic [ID_W-1:0]          active_id,
   output logic                     tone_done,
   output logic                     done_aborted,
   output logic                     busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   localparam int PS_W = $clog2(TICK_CYC + 1);
   localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_CYC - 1);
   localparam logic [DUR_W-1:0] GAP_LEN = DUR_W'(GAP_MS);

   logic [1:0]       state;
   logic [ID_W-1:0]  ptr;
   logic [PS_W-1:0]  presc;
   logic [DUR_W-1:0] remaining;

   logic [ID_W:0]    scan;
   logic             found;
   logic             grant;
   logic [ID_W-1:0]  grant_id;
   logic [HP_W-1:0]  grant_hp;
   logic [DUR_W-1:0] grant_dur;

   // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      req_ready = '0;
      found     = 1'b0;
      scan      = '0;
      if (state == ST_IDLE) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[scan[ID_W-1:0]]) begin
               req_ready[scan[ID_W-1:0]] = 1'b1;
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      grant_id  = '0;
      grant_hp  = '0;
      grant_dur = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            grant_id  = ID_W'(i);
            grant_hp  = req_half_period[i*HP_W +: HP_W];
            grant_dur = req_dur_ms[i*DUR_W +: DUR_W];
         end
      end
   end

   assign grant = |req_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state            <= ST_IDLE;
         ptr              <= '0;
         presc            <= '0;
         remaining        <= '0;
         tone_on          <= 1'b0;
         tone_half_period <= '0;
         active_id        <= '0;
         tone_done        <= 1'b0;
         done_aborted     <= 1'b0;
         busy             <= 1'b0;
      end else begin
         tone_done    <= 1'b0;
         done_aborted <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  tone_half_period <= grant_hp;
                  active_id        <= grant_id;
                  ptr              <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                  presc            <= '0;
                  // A zero duration or a zero half-period completes at once without a tone.
                  if (grant_dur != '0 && grant_hp != '0) begin
                     remaining <= grant_dur;
                     state     <= ST_PLAY;
                     tone_on   <= 1'b1;
                     busy      <= 1'b1;
                  end else begin
                     tone_done <= 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               // An abort on the final wrap still reports the tone as aborted.
               if (abort || (presc == PS_LAST && remaining == DUR_W'(1))) begin
                  tone_on      <= 1'b0;
                  tone_done    <= 1'b1;
                  done_aborted <= abort;
                  presc        <= '0;
                  if (GAP_MS == 0) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state     <= ST_GAP;
                     remaining <= GAP_LEN;
                  end
               end else if (presc == PS_LAST) begin
                  presc     <= '0;
                  remaining <= remaining - 1'b1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            ST_GAP: begin
               if (presc == PS_LAST) begin
                  presc <= '0;
                  if (remaining == DUR_W'(1)) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               tone_on <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
